// File: rtl/ppu_vram_pkg.sv
// Shared types and constants for the PPU VRAM access controller (PPUADDR/PPUDATA engine).
package ppu_vram_pkg;

  localparam int ADDR_W = 14;

  localparam logic [2:0] REG_PPUADDR = 3'd6;
  localparam logic [2:0] REG_PPUDATA = 3'd7;

  localparam logic [ADDR_W-1:0] INC_1  = 14'd1;
  localparam logic [ADDR_W-1:0] INC_32 = 14'd32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    WR,
    RD,
    DONE
  } state_e;

  // The 14-bit sum wraps naturally at 0x3FFF.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic inc32);
    return a + (inc32 ? INC_32 : INC_1);
  endfunction

endpackage

// File: rtl/ppu_wr_fifo.sv
// Write queue for PPUDATA writes: synchronous FIFO, async active-low reset, head visible combinationally.
module ppu_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ppu_vram_access_ctrl.sv
// CPU-side PPUADDR/PPUDATA engine: address latch, increment, read buffer and PPU bus master.
// Define PPU_WR_QUEUE_EN to buffer PPUDATA writes in a WRQ_DEPTH-entry queue.
module ppu_vram_access_ctrl
  import ppu_vram_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int WRQ_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_sel,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic        inc32,
  input  logic        latch_clr,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [13:0] mem_addr,
  output logic        mem_wr_req,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        busy,
  output logic        ovr_err
);

  localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY);

  state_e      state_q;
  logic [13:0] v_q, v_d;
  logic [5:0]  t_hi_q;
  logic        w_q;
  logic [7:0]  rbuf_q, reg_dout_q, cap_data_q, mem_din_q;
  logic        cap_rd_q, mem_req_q, mem_wr_req_q, ovr_q;
  logic [2:0]  cnt_q;
  logic [13:0] mem_addr_q;

  logic addr_wr, data_wr, data_rd;
  logic acc_wr, acc_rd, drop, v_inc;
  logic fifo_empty, fifo_start, start;
  logic [21:0] fifo_head;
  logic [13:0] start_addr;
  logic [7:0]  start_data;
  logic        start_rd;

  // A write always beats a simultaneous read; latch_clr suppresses a PPUADDR write entirely.
  assign addr_wr = reg_wr && (reg_sel == REG_PPUADDR) && !latch_clr;
  assign data_wr = reg_wr && (reg_sel == REG_PPUDATA);
  assign data_rd = !reg_wr && reg_rd && (reg_sel == REG_PPUDATA);

`ifdef PPU_WR_QUEUE_EN
  logic fifo_push, fifo_full;
  assign fifo_push  = data_wr && !fifo_full;
  assign acc_wr     = 1'b0;
  assign acc_rd     = data_rd && (state_q == IDLE) && fifo_empty;
  assign drop       = (data_wr && fifo_full) || (data_rd && !acc_rd);
  assign v_inc      = fifo_push || acc_rd;
  assign fifo_start = !fifo_empty && ((state_q == IDLE) || (state_q == DONE));

  // Head stays queued while in flight and is popped once its strobe has been issued.
  ppu_wr_fifo #(
    .DEPTH(WRQ_DEPTH),
    .WIDTH(22)
  ) u_wr_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .din_i  ({v_q, reg_din}),
    .pop_i  (state_q == WR),
    .dout_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
`else
  logic unused_wrq;
  assign unused_wrq = (WRQ_DEPTH > 0);
  assign acc_wr     = data_wr && (state_q == IDLE);
  assign acc_rd     = data_rd && (state_q == IDLE);
  assign drop       = (data_wr || data_rd) && (state_q != IDLE);
  assign v_inc      = acc_wr || acc_rd;
  assign fifo_empty = 1'b1;
  assign fifo_start = 1'b0;
  assign fifo_head  = '0;
`endif

  assign start = acc_wr || acc_rd || fifo_start;

  always_comb begin
    start_addr = v_q;
    start_data = reg_din;
    start_rd   = acc_rd;
    if (fifo_start) begin
      start_addr = fifo_head[21:8];
      start_data = fifo_head[7:0];
      start_rd   = 1'b0;
    end
  end

  always_comb begin
    v_d = v_q;
    if (v_inc)              v_d = next_addr(v_q, inc32);
    else if (addr_wr && w_q) v_d = {t_hi_q, reg_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      v_q          <= '0;
      t_hi_q       <= '0;
      w_q          <= 1'b0;
      rbuf_q       <= '0;
      reg_dout_q   <= '0;
      cap_data_q   <= '0;
      cap_rd_q     <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wr_req_q <= 1'b0;
      mem_din_q    <= '0;
      ovr_q        <= 1'b0;
    end else begin
      v_q <= v_d;
      if (latch_clr) begin
        w_q <= 1'b0;
      end else if (addr_wr) begin
        w_q <= !w_q;
        if (!w_q) t_hi_q <= reg_din[5:0];
      end
      if (drop)   ovr_q      <= 1'b1;
      if (acc_rd) reg_dout_q <= rbuf_q;

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= WAIT_GRANT;
            mem_req_q  <= 1'b1;
            mem_addr_q <= start_addr;
            cap_data_q <= start_data;
            cap_rd_q   <= start_rd;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT_GRANT: begin
          if (mem_grant) begin
            cnt_q <= '0;
            if (cap_rd_q) begin
              state_q <= RD;
            end else begin
              state_q      <= WR;
              mem_wr_req_q <= 1'b1;
              mem_din_q    <= cap_data_q;
            end
          end
        end
        WR: begin
          mem_wr_req_q <= 1'b0;
          mem_req_q    <= 1'b0;
          state_q      <= DONE;
        end
        RD: begin
          // Losing the grant mid-read restarts the whole latency window.
          if (!mem_grant) begin
            state_q <= WAIT_GRANT;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            rbuf_q    <= mem_dout;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_dout   = reg_dout_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_din    = mem_din_q;
  assign ovr_err    = ovr_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ppu_vram_access_ctrl.sv
// Scoreboard bench for ppu_vram_access_ctrl with a pipelined VRAM slave model.
module tb_ppu_vram_access_ctrl;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr = 1'b0, reg_rd = 1'b0, inc32 = 1'b0, latch_clr = 1'b0, mem_grant = 1'b0;
  logic [2:0]  reg_sel = 3'd0;
  logic [7:0]  reg_din = 8'd0;
  logic [7:0]  reg_dout, mem_din, mem_dout;
  logic        mem_req, mem_wr_req, busy, ovr_err;
  logic [13:0] mem_addr;

  always #5 clk = ~clk;

  ppu_vram_access_ctrl #(.RD_LATENCY(RD_LAT), .WRQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_sel(reg_sel),
    .reg_din(reg_din), .reg_dout(reg_dout), .inc32(inc32), .latch_clr(latch_clr),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_wr_req(mem_wr_req),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy), .ovr_err(ovr_err)
  );

  int          n_cmp = 0, n_bad = 0;
  logic [21:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  vram [16384];
  logic [7:0]  rd_pipe [RD_LAT];
  logic [13:0] mv = 14'd0;
  logic [7:0]  mbuf = 8'd0, last_dout = 8'd0;
  logic        exp_ovr = 1'b0;
  logic        prev_wr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // VRAM slave: preloaded during reset, RD_LAT register stages on the read path.
  always @(posedge clk) begin
    if (!rst_n) begin
      vram[14'h2000] <= 8'h11; vram[14'h2001] <= 8'h22; vram[14'h2002] <= 8'h33;
      vram[14'h2003] <= 8'h44; vram[14'h2004] <= 8'h55; vram[14'h2005] <= 8'h66;
    end else if (mem_wr_req && mem_grant) begin
      vram[mem_addr] <= mem_din;
    end
    rd_pipe[0] <= vram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[RD_LAT-1];

  // Write monitor: every strobe is popped against the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_wr_req) begin
      check_eq("wr_grant", {31'd0, mem_grant}, 32'd1);
      check_eq("wr_single", {31'd0, prev_wr}, 32'd0);
      check_eq("wr_pending", exp_wr_q.size(), (exp_wr_q.size() > 0) ? exp_wr_q.size() : 1);
      if (exp_wr_q.size() > 0) begin
        check_eq("wr_addr_data", {10'd0, mem_addr, mem_din}, {10'd0, exp_wr_q.pop_front()});
      end
      $display("wr  addr=%04h data=%02h", mem_addr, mem_din);
    end
    prev_wr <= mem_wr_req;
  end

  task automatic pulse(input logic wr, input logic rd, input logic [2:0] sel, input logic [7:0] d);
    @(negedge clk);
    reg_wr = wr; reg_rd = rd; reg_sel = sel; reg_din = d;
    @(negedge clk);
    reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
    pulse(1'b1, 1'b0, 3'd6, hi);
    pulse(1'b1, 1'b0, 3'd6, lo);
    mv = {hi[5:0], lo};
  endtask

  task automatic data_write(input logic [7:0] d);
    wait_idle();
    exp_wr_q.push_back({mv, d});
    mv = mv + (inc32 ? 14'd32 : 14'd1);
    pulse(1'b1, 1'b0, 3'd7, d);
  endtask

  task automatic data_read();
    logic [7:0] e;
    wait_idle();
    exp_rd_q.push_back(mbuf);
    mbuf = vram[mv];
    mv = mv + (inc32 ? 14'd32 : 14'd1);
    pulse(1'b0, 1'b1, 3'd7, 8'h00);
    e = exp_rd_q.pop_front();
    check_eq("rd_dout", {24'd0, reg_dout}, {24'd0, e});
    last_dout = e;
    $display("rd  dout=%02h expected=%02h", reg_dout, e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int n;
    mem_grant = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
    check_eq("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
    check_eq("rst_mem_din", {24'd0, mem_din}, 32'd0);
    check_eq("rst_reg_dout", {24'd0, reg_dout}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ovr", {31'd0, ovr_err}, 32'd0);

    // Basic write, then a second write proves v advanced to 0x2109.
    set_addr(8'h21, 8'h08);
    data_write(8'h5A);
    data_write(8'h5B);

    // Delayed read buffer: 0x00, 0x11, 0x22.
    set_addr(8'h20, 8'h00);
    repeat (3) data_read();

    // Increment wrap cases.
    wait_idle();
    inc32 = 1'b1;
    set_addr(8'h3F, 8'hF0);
    data_write(8'hA1);
    data_write(8'hA2);
    wait_idle();
    inc32 = 1'b0;
    set_addr(8'h3F, 8'hFF);
    data_write(8'hB1);
    data_write(8'hB2);

    // latch_clr discards the pending first byte.
    pulse(1'b1, 1'b0, 3'd6, 8'h23);
    @(negedge clk); latch_clr = 1'b1;
    @(negedge clk); latch_clr = 1'b0;
    set_addr(8'h24, 8'h00);
    data_write(8'hC1);

    // Simultaneous write and read: write wins, read ignored, no overrun.
    wait_idle();
    exp_wr_q.push_back({mv, 8'h77});
    mv = mv + 14'd1;
    pulse(1'b1, 1'b1, 3'd7, 8'h77);
    check_eq("simul_dout", {24'd0, reg_dout}, {24'd0, last_dout});
    check_eq("simul_ovr", {31'd0, ovr_err}, 32'd0);

`ifdef PPU_WR_QUEUE_EN
    wait_idle();
    set_addr(8'h25, 8'h00);
    mem_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        exp_wr_q.push_back({mv, 8'hD0 + 8'(i)});
        mv = mv + 14'd1;
      end
      pulse(1'b1, 1'b0, 3'd7, 8'hD0 + 8'(i));
      if (i == 3) check_eq("wrq_ovr_before", {31'd0, ovr_err}, 32'd0);
    end
    check_eq("wrq_ovr_full", {31'd0, ovr_err}, 32'd1);
    exp_ovr = 1'b1;
    mem_grant = 1'b1;
    wait_idle();
    check_eq("wrq_drained", exp_wr_q.size(), 32'd0);
`endif

    // Grant withheld, then a grant that drops during RD; a second access meanwhile is dropped.
    wait_idle();
    set_addr(8'h20, 8'h03);
    mem_grant = 1'b0;
    data_read();
    repeat (10) @(negedge clk);
    check_eq("nogrant_req", {31'd0, mem_req}, 32'd1);
    check_eq("nogrant_busy", {31'd0, busy}, 32'd1);
    check_eq("ovr_before_drop", {31'd0, ovr_err}, {31'd0, exp_ovr});
    pulse(1'b0, 1'b1, 3'd7, 8'h00);
    check_eq("ovr_after_drop", {31'd0, ovr_err}, 32'd1);
    exp_ovr = 1'b1;
    mem_grant = 1'b1;
    @(negedge clk);
    mem_grant = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("restart_req", {31'd0, mem_req}, 32'd1);
    mem_grant = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    check_eq("rd_window", n, RD_LAT + 1);
    data_read();
    data_read();

    // Asynchronous reset while the write strobe is high.
    wait_idle();
    exp_wr_q.push_back({mv, 8'hEE});
    pulse(1'b1, 1'b0, 3'd7, 8'hEE);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_wr_req) break;
      @(negedge clk);
      n++;
    end
    check_eq("wr_seen_before_rst", {31'd0, mem_wr_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_wr", {31'd0, mem_wr_req}, 32'd0);
    check_eq("rst_async_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_async_ovr", {31'd0, ovr_err}, 32'd0);
    check_eq("wr_all_seen", exp_wr_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
